aes_encrypt_controller: RTL



---
 rtl/aes_encrypt_controller.sv | 108 ++++++++++
 1 files changed

// File: rtl/aes_encrypt_controller.sv
// Control FSM for the AES-128 forward cipher datapath: sequences key expansion,
// the initial AddRoundKey, NUM_ROUNDS-1 full rounds and the final round without MixColumns.
module aes_encrypt_controller #(
  parameter int KEY_CYCLES = 25,
  parameter int NUM_ROUNDS = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AES_START,
  output logic [1:0] SELECT,
  output logic [1:0] MC_col,
  output logic [3:0] ROUND,
  output logic       Load_Reg,
  output logic       Load_MC,
  output logic       Key_Exp_En,
  output logic       AES_DONE
);

  localparam int KW = (KEY_CYCLES > 1) ? $clog2(KEY_CYCLES) : 1;

  localparam logic [1:0] SEL_SB  = 2'b00;
  localparam logic [1:0] SEL_SR  = 2'b01;
  localparam logic [1:0] SEL_ARK = 2'b10;
  localparam logic [1:0] SEL_MC  = 2'b11;

  typedef enum logic [3:0] {
    WAIT, KEY_EXP, ARK_INIT, SB, SR, MC0, MC1, MC2, MC3, MC_WB, ARK,
    SB_F, SR_F, ARK_F, DONE
  } state_t;

  state_t        state, state_next;
  logic [KW-1:0] key_cnt;
  logic [3:0]    round_cnt;
  logic          key_last;

  assign key_last = (key_cnt == KW'(KEY_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= WAIT;
    end else begin
      state <= state_next;
    end
  end

  // key_cnt only runs inside KEY_EXP; round_cnt advances on leaving each AddRoundKey
  always_ff @(posedge CLK) begin
    if (RESET) begin
      key_cnt   <= '0;
      round_cnt <= '0;
    end else begin
      key_cnt <= (state == KEY_EXP && !key_last) ? key_cnt + KW'(1) : '0;
      case (state)
        WAIT:         round_cnt <= '0;
        ARK_INIT, ARK: round_cnt <= round_cnt + 4'd1;
        DONE:         if (!AES_START) round_cnt <= '0;
        default:      round_cnt <= round_cnt;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT:     if (AES_START) state_next = KEY_EXP;
      KEY_EXP:  if (key_last) state_next = ARK_INIT;
      ARK_INIT: state_next = SB;
      SB:       state_next = SR;
      SR:       state_next = MC0;
      MC0:      state_next = MC1;
      MC1:      state_next = MC2;
      MC2:      state_next = MC3;
      MC3:      state_next = MC_WB;
      MC_WB:    state_next = ARK;
      ARK:      state_next = (round_cnt == 4'(NUM_ROUNDS - 1)) ? SB_F : SB;
      SB_F:     state_next = SR_F;
      SR_F:     state_next = ARK_F;
      ARK_F:    state_next = DONE;
      DONE:     if (!AES_START) state_next = WAIT;
      default:  state_next = WAIT;
    endcase
  end

  always_comb begin
    SELECT     = SEL_SB;
    MC_col     = 2'd0;
    Load_Reg   = 1'b0;
    Load_MC    = 1'b0;
    Key_Exp_En = 1'b0;
    AES_DONE   = 1'b0;
    case (state)
      KEY_EXP:              Key_Exp_En = 1'b1;
      ARK_INIT, ARK, ARK_F: begin SELECT = SEL_ARK; Load_Reg = 1'b1; end
      SB, SB_F:             begin SELECT = SEL_SB;  Load_Reg = 1'b1; end
      SR, SR_F:             begin SELECT = SEL_SR;  Load_Reg = 1'b1; end
      MC0:                  begin SELECT = SEL_MC; Load_MC = 1'b1; MC_col = 2'd0; end
      MC1:                  begin SELECT = SEL_MC; Load_MC = 1'b1; MC_col = 2'd1; end
      MC2:                  begin SELECT = SEL_MC; Load_MC = 1'b1; MC_col = 2'd2; end
      MC3:                  begin SELECT = SEL_MC; Load_MC = 1'b1; MC_col = 2'd3; end
      MC_WB:                begin SELECT = SEL_MC; Load_Reg = 1'b1; end
      DONE:                 AES_DONE = 1'b1;
      default:              ;
    endcase
  end

  assign ROUND = round_cnt;

endmodule
